// File: rtl/fifo_stream_packer.sv
// Packs RATIO consecutive narrow beats into one wide word on a registered valid/ready output.
// in_last closes a word early; out_keep marks the lanes that hold data.
module fifo_stream_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int CNT_WIDTH  = $clog2(RATIO)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [DATA_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]            out_keep,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready
);

  logic [CNT_WIDTH-1:0]        cnt_r;
  logic [DATA_WIDTH*RATIO-1:0] acc_r;
  logic [RATIO-1:0]            keep_r;

  logic                        in_fire_s;
  logic                        out_fire_s;
  logic                        completing_s;
  logic [RATIO-1:0]            keep_next_s;
  logic [DATA_WIDTH*RATIO-1:0] merged_s;
  logic [DATA_WIDTH-1:0]       lane_s;

  assign in_ready     = ~out_valid | out_ready;
  assign in_fire_s    = in_valid & in_ready;
  assign out_fire_s   = out_valid & out_ready;
  assign completing_s = (cnt_r == CNT_WIDTH'(RATIO - 1)) | in_last;

  // Accumulator with the incoming beat merged at lane cnt; lanes without keep forced to zero.
  always_comb begin
    keep_next_s = keep_r;
    merged_s    = '0;
    lane_s      = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_r == CNT_WIDTH'(i)) begin
        keep_next_s[i] = 1'b1;
        lane_s         = in_data;
      end else begin
        lane_s         = acc_r[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (keep_next_s[i]) begin
        merged_s[i*DATA_WIDTH +: DATA_WIDTH] = lane_s;
      end else begin
        merged_s[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Lane counter and partial-word accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      acc_r  <= '0;
      keep_r <= '0;
    end else if (in_fire_s && completing_s) begin
      cnt_r  <= '0;
      acc_r  <= '0;
      keep_r <= '0;
    end else if (in_fire_s) begin
      cnt_r  <= cnt_r + CNT_WIDTH'(1);
      acc_r  <= merged_s;
      keep_r <= keep_next_s;
    end else begin
      cnt_r  <= cnt_r;
      acc_r  <= acc_r;
      keep_r <= keep_r;
    end
  end

  // Output word register; a completing beat replaces the word even while it is being consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_fire_s && completing_s) begin
      out_data  <= merged_s;
      out_keep  <= keep_next_s;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_fire_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_fifo_stream_packer.sv
// Directed self-checking bench for fifo_stream_packer with DATA_WIDTH=8, RATIO=4.
module tb_fifo_stream_packer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  fifo_stream_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic push(input logic [7:0] d, input logic l);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check_val("push_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [31:0] word_exp;
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    check_val("rst_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_data",  {32'd0, out_data},  64'd0);
    check_val("rst_keep",  {60'd0, out_keep},  64'd0);
    check_val("rst_last",  {63'd0, out_last},  64'd0);
    check_val("rst_ready", {63'd0, in_ready},  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full word, no last.
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b0);
    @(negedge clk);
    check_val("full_data",  {32'd0, out_data},  64'h44332211);
    check_val("full_keep",  {60'd0, out_keep},  64'hF);
    check_val("full_last",  {63'd0, out_last},  64'd0);
    check_val("full_valid", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    check_val("full_valid_drop", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // Early flush with in_last, then next beat lands in lane 0.
    push(8'hAA, 1'b0); push(8'hBB, 1'b1);
    @(negedge clk);
    check_val("part_data",  {32'd0, out_data},  64'h0000BBAA);
    check_val("part_keep",  {60'd0, out_keep},  64'h3);
    check_val("part_last",  {63'd0, out_last},  64'd1);
    check_val("part_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
    push(8'h77, 1'b0); push(8'h66, 1'b1);
    @(negedge clk);
    check_val("lane0_data", {32'd0, out_data}, 64'h00006677);
    check_val("lane0_keep", {60'd0, out_keep}, 64'h3);
    @(posedge clk);
    #1;

    // Backpressure: word held stable, offered beat must not be taken.
    out_ready = 1'b0;
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h99;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("stall_data",  {32'd0, out_data}, 64'h04030201);
      check_val("stall_ready", {63'd0, in_ready}, 64'd0);
    end
    check_val("stall_keep",  {60'd0, out_keep},  64'hF);
    check_val("stall_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    @(negedge clk);
    check_val("release_ready", {63'd0, in_ready},  64'd1);
    check_val("release_valid", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    check_val("release_drop",  {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // Continuous 12 beats, one word every 4 cycles.
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(k);
      in_last  = 1'b0;
      @(negedge clk);
      check_val("stream_ready", {63'd0, in_ready}, 64'd1);
      if (k > 0 && (k % 4) == 0) begin
        word_exp = {8'h13 + 8'(k - 4), 8'h12 + 8'(k - 4), 8'h11 + 8'(k - 4), 8'h10 + 8'(k - 4)};
        check_val("stream_valid", {63'd0, out_valid}, 64'd1);
        check_val("stream_data",  {32'd0, out_data},  {32'd0, word_exp});
      end else begin
        check_val("stream_idle", {63'd0, out_valid}, 64'd0);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_val("stream_last_valid", {63'd0, out_valid}, 64'd1);
    check_val("stream_last_data",  {32'd0, out_data},  64'h1B1A1918);
    @(posedge clk);
    #1;

    // Single beat with in_last at lane 0.
    push(8'h5A, 1'b1);
    @(negedge clk);
    check_val("single_data", {32'd0, out_data}, 64'h0000005A);
    check_val("single_keep", {60'd0, out_keep}, 64'h1);
    check_val("single_last", {63'd0, out_last}, 64'd1);
    @(posedge clk);
    #1;

    // Reset mid-word discards the partial lanes.
    push(8'hE1, 1'b0); push(8'hE2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check_val("mid_rst_data",  {32'd0, out_data},  64'd0);
    check_val("mid_rst_keep",  {60'd0, out_keep},  64'd0);
    check_val("mid_rst_last",  {63'd0, out_last},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b0);
    @(negedge clk);
    check_val("post_rst_data",  {32'd0, out_data},  64'h04030201);
    check_val("post_rst_keep",  {60'd0, out_keep},  64'hF);
    check_val("post_rst_last",  {63'd0, out_last},  64'd0);
    check_val("post_rst_valid", {63'd0, out_valid}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
